// File: rtl/rob_writeback_pkg.sv
// Shared parameters, writeback lane ids and the record types used by the
// reorder buffer and its writeback bus.
package rob_writeback_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int CDB_SIZE  = 5;
   localparam int PADDR_W   = 6;
   localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

   typedef enum logic [2:0] {
      LANE_ALU = 3'd0,
      LANE_MUL = 3'd1,
      LANE_DIV = 3'd2,
      LANE_LS  = 3'd3,
      LANE_BR  = 3'd4
   } lane_e;

   // MSB of a pointer is the wrap bit, the rest index the entry array.
   typedef logic [ROB_IDX_W:0]   rob_ptr_t;
   typedef logic [ROB_IDX_W-1:0] rob_idx_t;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc_rdata;
      logic [31:0] pc_wdata;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
   } rvfi_t;

   typedef struct packed {
      logic        valid;
      logic        flush;
      rob_idx_t    rob_entry;
      logic [31:0] rd_data;
      logic [31:0] pc_wdata;
      rvfi_t       rvfi;
   } CDB_t;

   typedef struct packed {
      logic               valid;
      logic               done;
      logic               flush_bit;
      logic [4:0]         rd_addr;
      logic [PADDR_W-1:0] rd_paddr;
      logic [PADDR_W-1:0] old_paddr;
      logic [31:0]        rd_data;
      logic [31:0]        pc_wdata;
      rvfi_t              rvfi;
   } rob_entry_t;

   function automatic rob_ptr_t ptr_next(input rob_ptr_t p);
      return p + 1'b1;
   endfunction

endpackage

// File: rtl/rob_writeback_ptr.sv
// Wrapped head/tail pointer: load has priority over increment.
module rob_ptr
   import rob_writeback_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     inc,
   input  logic     load,
   input  rob_ptr_t load_val,
   output rob_ptr_t ptr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= load_val;
      end else if (inc) begin
         ptr <= ptr_next(ptr);
      end
   end

endmodule

// File: rtl/rob_writeback.sv
// Reorder buffer: in-order allocate at dispatch, out-of-order completion from
// the writeback bus, in-order retirement with flush/redirect on a flagged entry.
module rob_writeback
   import rob_writeback_pkg::*;
#(
   parameter int ROB_DEPTH = rob_writeback_pkg::ROB_DEPTH,
   parameter int CDB_SIZE  = rob_writeback_pkg::CDB_SIZE,
   parameter int PADDR_W   = rob_writeback_pkg::PADDR_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         dispatch_valid,
   output logic                         dispatch_ready,
   input  logic [4:0]                   dispatch_rd_addr,
   input  logic [PADDR_W-1:0]           dispatch_rd_paddr,
   input  logic [PADDR_W-1:0]           dispatch_old_paddr,
   output logic [$clog2(ROB_DEPTH)-1:0] dispatch_rob_entry,
   input  CDB_t [CDB_SIZE-1:0]          WB_Bus,
   output logic                         commit_valid,
   output logic [4:0]                   commit_rd_addr,
   output logic [PADDR_W-1:0]           commit_rd_paddr,
   output logic [PADDR_W-1:0]           commit_old_paddr,
   output rvfi_t                        commit_rvfi,
   output logic                         flush,
   output logic [31:0]                  flush_pc,
   output logic                         empty
);

   localparam int IDX_W = $clog2(ROB_DEPTH);

   rob_entry_t rob [ROB_DEPTH];
   rob_ptr_t   head, tail;
   logic [IDX_W-1:0] head_idx, tail_idx;
   rob_entry_t head_e;
   logic       full, dispatch_fire, commit_go, flush_go;
   rvfi_t      wb_rvfi [CDB_SIZE];

   assign head_idx = head[IDX_W-1:0];
   assign tail_idx = tail[IDX_W-1:0];
   assign head_e   = rob[head_idx];

   assign empty = (head == tail);
   assign full  = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);

   assign dispatch_ready     = !full && !flush;
   assign dispatch_fire      = dispatch_valid && dispatch_ready;
   assign dispatch_rob_entry = tail_idx;

   assign commit_go = head_e.valid && head_e.done;
   assign flush_go  = commit_go && head_e.flush_bit;

   // A flush-causing commit overrides both pointers, discarding any dispatch.
   rob_ptr u_head (
      .clk      (clk),
      .rst      (rst),
      .inc      (commit_go && !flush_go),
      .load     (flush_go),
      .load_val (ptr_next(head)),
      .ptr      (head)
   );

   rob_ptr u_tail (
      .clk      (clk),
      .rst      (rst),
      .inc      (dispatch_fire && !flush_go),
      .load     (flush_go),
      .load_val (ptr_next(head)),
      .ptr      (tail)
   );

   always_comb begin
      for (int i = 0; i < CDB_SIZE; i++) begin
         wb_rvfi[i]          = WB_Bus[i].rvfi;
         wb_rvfi[i].rd_wdata = WB_Bus[i].rd_data;
         wb_rvfi[i].pc_wdata = WB_Bus[i].pc_wdata;
      end
   end

   // Entry array: only valid/done are reset; payload fields are written on use.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            rob[i].valid <= 1'b0;
            rob[i].done  <= 1'b0;
         end
      end else begin
         if (flush_go) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
               rob[i].valid <= 1'b0;
            end
         end else begin
            if (commit_go) begin
               rob[head_idx].valid <= 1'b0;
            end
            if (dispatch_fire) begin
               rob[tail_idx].valid     <= 1'b1;
               rob[tail_idx].done      <= 1'b0;
               rob[tail_idx].flush_bit <= 1'b0;
               rob[tail_idx].rd_addr   <= dispatch_rd_addr;
               rob[tail_idx].rd_paddr  <= dispatch_rd_paddr;
               rob[tail_idx].old_paddr <= dispatch_old_paddr;
            end
         end
         // Later lanes overwrite earlier ones on a (illegal) same-entry hit.
         if (!flush) begin
            for (int i = 0; i < CDB_SIZE; i++) begin
               if (WB_Bus[i].valid && rob[WB_Bus[i].rob_entry].valid) begin
                  rob[WB_Bus[i].rob_entry].done      <= 1'b1;
                  rob[WB_Bus[i].rob_entry].flush_bit <= WB_Bus[i].flush;
                  rob[WB_Bus[i].rob_entry].rd_data   <= WB_Bus[i].rd_data;
                  rob[WB_Bus[i].rob_entry].pc_wdata  <= WB_Bus[i].pc_wdata;
                  rob[WB_Bus[i].rob_entry].rvfi      <= wb_rvfi[i];
               end
            end
         end
      end
   end

   // Commit stage boundary: retirement outputs are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         commit_valid     <= 1'b0;
         commit_rd_addr   <= '0;
         commit_rd_paddr  <= '0;
         commit_old_paddr <= '0;
         commit_rvfi      <= '0;
         flush            <= 1'b0;
         flush_pc         <= '0;
      end else begin
         commit_valid <= commit_go;
         flush        <= flush_go;
         if (commit_go) begin
            commit_rd_addr   <= head_e.rd_addr;
            commit_rd_paddr  <= head_e.rd_paddr;
            commit_old_paddr <= head_e.old_paddr;
            commit_rvfi      <= head_e.rvfi;
         end
         if (flush_go) begin
            flush_pc <= head_e.pc_wdata;
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < CDB_SIZE; i++) begin
            for (int j = i + 1; j < CDB_SIZE; j++) begin
               assert (!(WB_Bus[i].valid && WB_Bus[j].valid &&
                         WB_Bus[i].rob_entry == WB_Bus[j].rob_entry));
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_rob_writeback.sv
// Scoreboard bench for rob_writeback: expected commits are queued in program
// order at dispatch and popped by a monitor whenever commit_valid is seen.
module tb_rob_writeback;
   import rob_writeback_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dispatch_valid = 1'b0;
   logic        dispatch_ready;
   logic [4:0]  dispatch_rd_addr = '0;
   logic [5:0]  dispatch_rd_paddr = '0;
   logic [5:0]  dispatch_old_paddr = '0;
   logic [3:0]  dispatch_rob_entry;
   CDB_t [CDB_SIZE-1:0] wb_bus = '0;
   logic        commit_valid;
   logic [4:0]  commit_rd_addr;
   logic [5:0]  commit_rd_paddr;
   logic [5:0]  commit_old_paddr;
   rvfi_t       commit_rvfi;
   logic        flush;
   logic [31:0] flush_pc;
   logic        empty;

   always #5 clk = ~clk;

   rob_writeback dut (
      .clk                (clk),
      .rst                (rst),
      .dispatch_valid     (dispatch_valid),
      .dispatch_ready     (dispatch_ready),
      .dispatch_rd_addr   (dispatch_rd_addr),
      .dispatch_rd_paddr  (dispatch_rd_paddr),
      .dispatch_old_paddr (dispatch_old_paddr),
      .dispatch_rob_entry (dispatch_rob_entry),
      .WB_Bus             (wb_bus),
      .commit_valid       (commit_valid),
      .commit_rd_addr     (commit_rd_addr),
      .commit_rd_paddr    (commit_rd_paddr),
      .commit_old_paddr   (commit_old_paddr),
      .commit_rvfi        (commit_rvfi),
      .flush              (flush),
      .flush_pc           (flush_pc),
      .empty              (empty)
   );

   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  rd;
      logic [5:0]  p;
      logic [5:0]  op;
      logic [31:0] data;
      logic [31:0] pc;
      bit          fl;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_commits = 0;
   int   seq = 0;

   always @(negedge clk) begin : monitor
      exp_t e;
      if (commit_valid === 1'b1) begin
         n_commits++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL commit_unexpected: got commit of paddr %0d, required no commit", commit_rd_paddr);
         end else begin
            e = exp_q.pop_front();
            n_checks++;
            if ({commit_rd_addr, commit_rd_paddr, commit_old_paddr} !== {e.rd, e.p, e.op}) begin
               n_fail++;
               $display("FAIL commit_regs tag %0d: got rd %0d p %0d old %0d, required rd %0d p %0d old %0d",
                        e.tag, commit_rd_addr, commit_rd_paddr, commit_old_paddr, e.rd, e.p, e.op);
            end
            n_checks++;
            if (commit_rvfi.rd_wdata !== e.data) begin
               n_fail++;
               $display("FAIL commit_rd_wdata tag %0d: got %h, required %h", e.tag, commit_rvfi.rd_wdata, e.data);
            end
            n_checks++;
            if (commit_rvfi.pc_wdata !== e.pc) begin
               n_fail++;
               $display("FAIL commit_pc_wdata tag %0d: got %h, required %h", e.tag, commit_rvfi.pc_wdata, e.pc);
            end
            n_checks++;
            if (flush !== e.fl) begin
               n_fail++;
               $display("FAIL commit_flush tag %0d: got %b, required %b", e.tag, flush, e.fl);
            end
            if (e.fl) begin
               n_checks++;
               if (flush_pc !== e.pc) begin
                  n_fail++;
                  $display("FAIL flush_pc tag %0d: got %h, required %h", e.tag, flush_pc, e.pc);
               end
               exp_q.delete();
            end
         end
      end else if (flush !== 1'b0) begin
         n_checks++;
         n_fail++;
         $display("FAIL flush_without_commit: got flush %b, required 0", flush);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      dispatch_valid = 1'b0;
      wb_bus = '0;
      tick(2);
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic dispatch(input logic [4:0] rd, input logic [5:0] p, input logic [5:0] op,
                           output logic fired, output logic [3:0] tag);
      exp_t e;
      dispatch_valid     = 1'b1;
      dispatch_rd_addr   = rd;
      dispatch_rd_paddr  = p;
      dispatch_old_paddr = op;
      fired = dispatch_ready;
      tag   = dispatch_rob_entry;
      if (fired) begin
         e.tag  = tag;
         e.rd   = rd;
         e.p    = p;
         e.op   = op;
         e.data = 32'hDA7A_0000 + 32'(seq);
         e.pc   = 32'h4000_0000 + 32'(seq * 4);
         e.fl   = 1'b0;
         seq++;
         exp_q.push_back(e);
      end
      tick();
      dispatch_valid = 1'b0;
   endtask

   task automatic set_lane(input int lane, input logic [3:0] tag, input bit fl, input logic [31:0] fpc);
      int k;
      logic [31:0] data, pc;
      logic [4:0]  rd;
      k = -1;
      foreach (exp_q[j]) if (k < 0 && exp_q[j].tag == tag) k = j;
      if (k >= 0) begin
         if (fl) exp_q[k].pc = fpc;
         exp_q[k].fl = fl;
         data = exp_q[k].data;
         pc   = exp_q[k].pc;
         rd   = exp_q[k].rd;
      end else begin
         data = 32'hBAD0_0000 | 32'(tag);
         pc   = 32'hBAD1_0000;
         rd   = 5'd31;
      end
      wb_bus[lane].valid          = 1'b1;
      wb_bus[lane].flush          = fl;
      wb_bus[lane].rob_entry      = tag;
      wb_bus[lane].rd_data        = data;
      wb_bus[lane].pc_wdata       = pc;
      wb_bus[lane].rvfi.insn      = 32'h0000_0013;
      wb_bus[lane].rvfi.pc_rdata  = pc - 32'd4;
      wb_bus[lane].rvfi.pc_wdata  = pc;
      wb_bus[lane].rvfi.rd_addr   = rd;
      wb_bus[lane].rvfi.rd_wdata  = data;
   endtask

   task automatic pulse_bus();
      tick();
      wb_bus = '0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({empty, commit_valid, flush, dispatch_ready} !== 4'b1001) begin
         n_fail++;
         $display("FAIL reset_ctrl: got empty/cv/flush/ready %b, required 1001", {empty, commit_valid, flush, dispatch_ready});
      end
      n_checks++;
      if (flush_pc !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_flush_pc: got %h, required 0", flush_pc);
      end
      n_checks++;
      if ({commit_rd_addr, commit_rd_paddr, commit_old_paddr, commit_rvfi} !== '0) begin
         n_fail++;
         $display("FAIL reset_commit_outputs: got nonzero, required 0");
      end
      n_checks++;
      if (dispatch_rob_entry !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_tag: got %0d, required 0", dispatch_rob_entry);
      end
   endtask

   task automatic test_dispatch_order();
      logic f;
      logic [3:0] t;
      for (int i = 0; i < 3; i++) begin
         dispatch(5'(i + 1), 6'(33 + i), 6'(10 + i), f, t);
         n_checks++;
         if ({f, t} !== {1'b1, 4'(i)}) begin
            n_fail++;
            $display("FAIL dispatch_tag %0d: got fired %b tag %0d, required fired 1 tag %0d", i, f, t, i);
         end
      end
      n_checks++;
      if ({empty, commit_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL dispatch_state: got empty/cv %b, required 00", {empty, commit_valid});
      end
   endtask

   task automatic test_out_of_order_wb();
      set_lane(int'(LANE_ALU), 4'd1, 1'b0, 32'd0);
      pulse_bus();
      tick();
      n_checks++;
      if (commit_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ooo_no_commit_early: got cv %b, required 0", commit_valid);
      end
      set_lane(int'(LANE_MUL), 4'd0, 1'b0, 32'd0);
      pulse_bus();
      n_checks++;
      if (commit_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ooo_latency: got cv %b one cycle after beat, required 0", commit_valid);
      end
      tick();
      n_checks++;
      if ({commit_valid, commit_rd_paddr} !== {1'b1, 6'd33}) begin
         n_fail++;
         $display("FAIL ooo_commit0: got cv %b paddr %0d, required cv 1 paddr 33", commit_valid, commit_rd_paddr);
      end
      tick();
      n_checks++;
      if ({commit_valid, commit_rd_paddr} !== {1'b1, 6'd34}) begin
         n_fail++;
         $display("FAIL ooo_commit1: got cv %b paddr %0d, required cv 1 paddr 34", commit_valid, commit_rd_paddr);
      end
      tick();
      n_checks++;
      if (commit_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ooo_stop_at_tag2: got cv %b, required 0", commit_valid);
      end
   endtask

   task automatic test_full();
      logic f;
      logic [3:0] t;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         dispatch(5'(i), 6'(20 + i), 6'(i), f, t);
         n_checks++;
         if ({f, t} !== {1'b1, 4'(i)}) begin
            n_fail++;
            $display("FAIL full_fill %0d: got fired %b tag %0d, required fired 1 tag %0d", i, f, t, i);
         end
      end
      n_checks++;
      if ({dispatch_ready, empty} !== 2'b00) begin
         n_fail++;
         $display("FAIL full_ready: got ready/empty %b, required 00", {dispatch_ready, empty});
      end
      dispatch(5'd17, 6'd60, 6'd61, f, t);
      tick(2);
      n_checks++;
      if ({f, dispatch_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL full_hold: got fired/ready %b, required 00", {f, dispatch_ready});
      end
      set_lane(int'(LANE_ALU), 4'd0, 1'b0, 32'd0);
      pulse_bus();
      tick();
      n_checks++;
      if ({commit_valid, dispatch_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL full_release: got cv/ready %b, required 11", {commit_valid, dispatch_ready});
      end
      dispatch(5'd17, 6'd60, 6'd61, f, t);
      n_checks++;
      if ({f, t, dispatch_ready} !== {1'b1, 4'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL full_wrap: got fired %b tag %0d ready %b, required fired 1 tag 0 ready 0", f, t, dispatch_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic f;
      logic [3:0] t;
      int c0;
      do_reset();
      for (int i = 0; i < 4; i++) dispatch(5'(i + 2), 6'(40 + i), 6'(50 + i), f, t);
      for (int i = 0; i < 4; i++) set_lane(i, 4'(i), 1'b0, 32'd0);
      pulse_bus();
      c0 = n_commits;
      for (int i = 0; i < 4; i++) begin
         dispatch(5'(i + 8), 6'(44 + i), 6'(54 + i), f, t);
         n_checks++;
         if ({f, t} !== {1'b1, 4'(4 + i)}) begin
            n_fail++;
            $display("FAIL b2b_tag %0d: got fired %b tag %0d, required fired 1 tag %0d", i, f, t, 4 + i);
         end
      end
      tick(3);
      n_checks++;
      if ((n_commits - c0) !== 4 || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_commits: got %0d commits empty %b, required 4 commits empty 0", n_commits - c0, empty);
      end
   endtask

   task automatic test_flush();
      logic f;
      logic [3:0] t;
      int c0;
      do_reset();
      for (int i = 0; i < 6; i++) dispatch(5'(i + 1), 6'(i + 1), 6'(i + 30), f, t);
      c0 = n_commits;
      set_lane(int'(LANE_ALU), 4'd0, 1'b0, 32'd0);
      set_lane(int'(LANE_MUL), 4'd1, 1'b0, 32'd0);
      set_lane(int'(LANE_BR),  4'd2, 1'b1, 32'h6000_0040);
      pulse_bus();
      tick(2);
      dispatch_valid     = 1'b1;
      dispatch_rd_addr   = 5'd9;
      dispatch_rd_paddr  = 6'd9;
      dispatch_old_paddr = 6'd9;
      n_checks++;
      if (dispatch_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_pre_ready: got %b, required 1", dispatch_ready);
      end
      tick();
      dispatch_valid = 1'b0;
      n_checks++;
      if ({commit_valid, flush, empty, dispatch_ready} !== 4'b1110 || flush_pc !== 32'h6000_0040) begin
         n_fail++;
         $display("FAIL flush_pulse: got cv/flush/empty/ready %b pc %h, required 1110 pc 60000040",
                  {commit_valid, flush, empty, dispatch_ready}, flush_pc);
      end
      set_lane(int'(LANE_LS), 4'd4, 1'b0, 32'd0);
      pulse_bus();
      n_checks++;
      if ({commit_valid, flush, empty} !== 3'b001) begin
         n_fail++;
         $display("FAIL flush_after: got cv/flush/empty %b, required 001", {commit_valid, flush, empty});
      end
      tick(3);
      n_checks++;
      if ((n_commits - c0) !== 3 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_drained: got %0d commits empty %b, required 3 commits empty 1", n_commits - c0, empty);
      end
      dispatch(5'd3, 6'd3, 6'd3, f, t);
      n_checks++;
      if ({f, t} !== {1'b1, 4'd3}) begin
         n_fail++;
         $display("FAIL flush_next_tag: got fired %b tag %0d, required fired 1 tag 3", f, t);
      end
   endtask

   task automatic test_unalloc();
      logic f;
      logic [3:0] t;
      int c0;
      do_reset();
      for (int i = 0; i < 2; i++) dispatch(5'(i + 4), 6'(i + 4), 6'(i + 14), f, t);
      c0 = n_commits;
      set_lane(int'(LANE_LS), 4'd9, 1'b0, 32'd0);
      pulse_bus();
      tick(3);
      n_checks++;
      if ((n_commits - c0) !== 0 || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL unalloc_ignored: got %0d commits empty %b, required 0 commits empty 0", n_commits - c0, empty);
      end
      for (int i = 2; i < 10; i++) dispatch(5'(i + 4), 6'(i + 4), 6'(i + 14), f, t);
      for (int i = 0; i < 5; i++) set_lane(i, 4'(i), 1'b0, 32'd0);
      pulse_bus();
      for (int i = 0; i < 4; i++) set_lane(i, 4'(i + 5), 1'b0, 32'd0);
      pulse_bus();
      tick(12);
      n_checks++;
      if ((n_commits - c0) !== 9 || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL unalloc_tag9_pending: got %0d commits empty %b, required 9 commits empty 0", n_commits - c0, empty);
      end
   endtask

   task automatic test_reset_mid();
      logic f;
      logic [3:0] t;
      for (int i = 0; i < 4; i++) dispatch(5'(i + 20), 6'(i + 20), 6'(i + 40), f, t);
      set_lane(int'(LANE_ALU), 4'd9, 1'b0, 32'd0);
      pulse_bus();
      rst = 1'b1;
      tick();
      exp_q.delete();
      n_checks++;
      if ({empty, commit_valid, flush} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_mid: got empty/cv/flush %b, required 100", {empty, commit_valid, flush});
      end
      rst = 1'b0;
      dispatch(5'd1, 6'd1, 6'd2, f, t);
      n_checks++;
      if ({f, t} !== {1'b1, 4'd0}) begin
         n_fail++;
         $display("FAIL reset_mid_tag: got fired %b tag %0d, required fired 1 tag 0", f, t);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required normal completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_dispatch_order();
      test_out_of_order_wb();
      test_full();
      test_back_to_back();
      test_flush();
      test_unalloc();
      test_reset_mid();
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
